// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for an 8-digit seven-segment display.
//
// The 64-bit segment bundle and 8-bit blank mask are copied into a shadow
// register only at frame boundaries (and on the first cycle after reset), so a
// displayed frame never mixes old and new data. One digit is then driven per
// DIV-cycle slot, with the first DEAD cycles of every slot dark.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   seg_i    per-digit segment patterns, digit k = seg_i[8k+7:8k], 1 = lit
//   blank_i  per-digit blank mask, 1 = digit dark
//   hold_i   1 = skip the frame-boundary capture (shadow frozen)
//   D        one-hot digit select, physical polarity per SEL_ACTIVE_LOW
//   o        segment pattern of the selected digit, polarity per SEG_ACTIVE_LOW
//   frame_o  one-cycle pulse, one cycle after each capture point

// Per-digit lane: decides whether digit K owns the pins this cycle and
// forwards its gated segment byte.
//   idx      current digit index
//   slot_on  past the dead time of the current slot
//   blank    shadowed blank bit of this digit
//   seg      shadowed segment byte of this digit
//   sel      this digit is lit
//   seg_o    segment byte if lit, else zero
module seg_scan_lane #(
  parameter int K = 0
) (
  input  logic [2:0] idx,
  input  logic       slot_on,
  input  logic       blank,
  input  logic [7:0] seg,
  output logic       sel,
  output logic [7:0] seg_o
);
  assign sel   = slot_on & (idx == 3'(K)) & ~blank;
  assign seg_o = sel ? seg : 8'h00;
endmodule

module seg_scan_mux #(
  parameter int DIV            = 50000,
  parameter int DEAD           = 2,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_i,
  input  logic [7:0]  blank_i,
  input  logic        hold_i,
  output logic [7:0]  D,
  output logic [7:0]  o,
  output logic        frame_o
);
  localparam int NUM_DIG = 8;
  localparam int CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [7:0] SEL_INV = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CW-1:0]              cnt;
  logic [2:0]                 idx;
  logic                       first;
  logic [NUM_DIG-1:0][7:0]    shadow_seg;
  logic [NUM_DIG-1:0]         shadow_blank;

  logic                       tick, cap, slot_on;
  logic [NUM_DIG-1:0]         lane_sel;
  logic [NUM_DIG-1:0][7:0]    lane_seg;
  logic [7:0]                 seg_or;

  assign tick = (cnt == CW'(DIV - 1));
  // Capture on the very first cycle after reset so digit 0 already shows
  // live data, then once per frame at the 7 -> 0 wrap.
  assign cap  = first | (tick & (idx == 3'd7));

  generate
    if (DEAD == 0) begin : g_nodead
      assign slot_on = 1'b1;
    end else begin : g_dead
      assign slot_on = (cnt >= CW'(DEAD));
    end
  endgenerate

  genvar k;
  generate
    for (k = 0; k < NUM_DIG; k++) begin : g_lane
      seg_scan_lane #(.K(k)) u_lane (
        .idx     (idx),
        .slot_on (slot_on),
        .blank   (shadow_blank[k]),
        .seg     (shadow_seg[k]),
        .sel     (lane_sel[k]),
        .seg_o   (lane_seg[k])
      );
    end
  endgenerate

  // At most one lane is selected, so OR-ing the gated bytes is a mux.
  always_comb begin
    seg_or = 8'h00;
    for (int i = 0; i < NUM_DIG; i++) seg_or = seg_or | lane_seg[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= 3'd0;
      first        <= 1'b1;
      shadow_seg   <= '0;
      shadow_blank <= '1;
      frame_o      <= 1'b0;
      D            <= SEL_INV;
      o            <= SEG_INV;
    end else begin
      first   <= 1'b0;
      frame_o <= cap;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (cap && !hold_i) begin
        shadow_seg   <= seg_i;
        shadow_blank <= blank_i;
      end
      D <= lane_sel ^ SEL_INV;
      o <= seg_or ^ SEG_INV;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two instances share stimulus.
//   a: DIV=4, DEAD=1, active-high pins
//   b: DIV=4, DEAD=0, active-low select and segment pins
// Expected pins come from a model indexed by the cycle count since reset
// release, with a shadow copy updated at frame boundaries.
module tb_seg_scan_mux;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seg;
  logic [7:0]  blank;
  logic        hold;
  logic [7:0]  d_a, o_a, d_b, o_b;
  logic        f_a, f_b;

  int total  = 0;
  int passed = 0;
  int c      = 0;
  logic [7:0] sh_seg [8];
  logic [7:0] sh_blank;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIV(DIV), .DEAD(1), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .seg_i(seg), .blank_i(blank), .hold_i(hold),
    .D(d_a), .o(o_a), .frame_o(f_a));

  seg_scan_mux #(.DIV(DIV), .DEAD(0), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .seg_i(seg), .blank_i(blank), .hold_i(hold),
    .D(d_b), .o(o_b), .frame_o(f_b));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d got=%h want=%h", tag, c, obs, exp);
  endtask

  task automatic model_reset();
    c = 0;
    sh_blank = 8'hFF;
    for (int k = 0; k < 8; k++) sh_seg[k] = 8'h00;
  endtask

  // One clock: predict from the model, clock, then compare 1 time unit later.
  task automatic cyc();
    int slot_pos, dig;
    bit cap, en_a, en_b;
    logic [7:0] onehot, ea_d, ea_o, eb_d, eb_o;
    slot_pos = c % DIV;
    dig      = (c / DIV) % 8;
    cap      = (c == 0) || (slot_pos == DIV - 1 && dig == 7);
    onehot   = 8'h01 << dig;
    en_a     = (slot_pos >= 1) && !sh_blank[dig];
    en_b     = !sh_blank[dig];
    ea_d     = en_a ? onehot : 8'h00;
    ea_o     = en_a ? sh_seg[dig] : 8'h00;
    eb_d     = ~(en_b ? onehot : 8'h00);
    eb_o     = ~(en_b ? sh_seg[dig] : 8'h00);
    if (cap && !hold) begin
      for (int k = 0; k < 8; k++) sh_seg[k] = seg[8*k +: 8];
      sh_blank = blank;
    end
    @(posedge clk);
    #1;
    chk("a_D", d_a, ea_d);
    chk("a_o", o_a, ea_o);
    chk("a_frame", {7'd0, f_a}, {7'd0, cap});
    chk("b_D", d_b, eb_d);
    chk("b_o", o_b, eb_o);
    chk("b_frame", {7'd0, f_b}, {7'd0, cap});
    c++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_slot(input int s);
    // bounded: one full frame at most
    for (int i = 0; i < 8 * DIV && ((c / DIV) % 8) != s; i++) cyc();
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_a_D"}, d_a, 8'h00);
    chk({tag, "_a_o"}, o_a, 8'h00);
    chk({tag, "_a_frame"}, {7'd0, f_a}, 8'h00);
    chk({tag, "_b_D"}, d_b, 8'hFF);
    chk({tag, "_b_o"}, o_b, 8'hFF);
  endtask

  initial begin
    rst   = 1'b1;
    seg   = 64'h0706050403020100;
    blank = 8'h00;
    hold  = 1'b0;
    #12;
    chk_reset_pins("rst0");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // basic scan, two frames
    run(64);

    // new data mid-frame must wait for the next boundary
    run_to_slot(3);
    cyc();
    seg = 64'hFFFF_FFFF_FFFF_FFFF;
    run(48);

    // hold across a wrap, then release
    run_to_slot(7);
    hold = 1'b1;
    seg  = {$urandom(), $urandom()};
    run(8);
    hold = 1'b0;
    run(40);

    // blank digits 1 and 3, digit 2 = 0x3F
    blank = 8'h0A;
    seg   = {$urandom(), $urandom()};
    seg[23:16] = 8'h3F;
    run(72);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7, 0) == 0) seg = {$urandom(), $urandom()};
      if ($urandom_range(15, 0) == 0) blank = 8'($urandom());
      hold = ($urandom_range(2, 0) == 0);
      cyc();
    end

    // asynchronous reset during slot 5
    blank = 8'h00;
    hold  = 1'b0;
    run_to_slot(5);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk_reset_pins("rst_mid");
    model_reset();
    seg = {$urandom(), $urandom()};
    @(negedge clk);
    rst = 1'b0;
    run(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
